ifns_decoder_seq: RTL and testbench

IFNS_DECODER_SEQ -- requirements
Module: ifns_decoder_seq

---
 rtl/ifns_decoder_seq.sv | 132 +++++++++++++
 tb/tb_ifns_decoder_seq.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/ifns_decoder_seq.sv
// Sequential Fibonacci-weighted codeword decoder that handles BPC bits per cycle, LSB first.
// Define IFNS_RANGE_CHECK_EN to saturate at 2^W and flag overflow on out_err; otherwise results wrap modulo 2^W.
module ifns_decoder_seq #(
  parameter int N   = 31,
  parameter int W   = 22,
  parameter int BPC = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_code,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_err
);

  localparam int C    = (N + BPC - 1) / BPC;
  localparam int CW   = C * BPC;
  localparam int CNTW = (C > 1) ? $clog2(C) : 1;

`ifdef IFNS_RANGE_CHECK_EN
  localparam int AW = W + 1;
  localparam logic [AW-1:0] SAT = {1'b1, {W{1'b0}}};

  // Once a value reaches 2^W it stays there, so bit W marks any overflow.
  function automatic logic [AW-1:0] add_w(input logic [AW-1:0] a, input logic [AW-1:0] b);
    logic [AW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s > {1'b0, SAT}) add_w = SAT;
    else                 add_w = s[AW-1:0];
  endfunction
`else
  localparam int AW = W;

  function automatic logic [AW-1:0] add_w(input logic [AW-1:0] a, input logic [AW-1:0] b);
    add_w = a + b;
  endfunction
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_reg;
  logic [CW-1:0]   code_reg;
  logic [AW-1:0]   acc_reg, wa_reg, wb_reg;
  logic [AW-1:0]   acc_next, wa_next, wb_next;
  logic [CNTW-1:0] cnt_reg;
  logic            valid_reg;
  logic [W-1:0]    data_reg;
`ifdef IFNS_RANGE_CHECK_EN
  logic            err_reg;
`endif

  // The code register is padded to a whole number of chunks, so positions >= N read as zero.
  always_comb begin
    acc_next = acc_reg;
    wa_next  = wa_reg;
    wb_next  = wb_reg;
    for (int j = 0; j < BPC; j++) begin
      if (code_reg[j]) acc_next = add_w(acc_next, wa_next);
      {wa_next, wb_next} = {wb_next, add_w(wa_next, wb_next)};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      code_reg  <= '0;
      acc_reg   <= '0;
      wa_reg    <= '0;
      wb_reg    <= '0;
      cnt_reg   <= '0;
      valid_reg <= 1'b0;
      data_reg  <= '0;
`ifdef IFNS_RANGE_CHECK_EN
      err_reg   <= 1'b0;
`endif
    end else if (clr) begin
      state_reg <= IDLE;
      valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            code_reg  <= CW'(in_code);
            acc_reg   <= '0;
            wa_reg    <= AW'(1);
            wb_reg    <= AW'(1);
            cnt_reg   <= '0;
            state_reg <= RUN;
          end
        end
        RUN: begin
          acc_reg  <= acc_next;
          wa_reg   <= wa_next;
          wb_reg   <= wb_next;
          code_reg <= code_reg >> BPC;
          cnt_reg  <= cnt_reg + CNTW'(1);
          if (cnt_reg == CNTW'(C - 1)) begin
            state_reg <= DONE;
            valid_reg <= 1'b1;
`ifdef IFNS_RANGE_CHECK_EN
            data_reg  <= acc_next[W] ? {W{1'b1}} : acc_next[W-1:0];
            err_reg   <= acc_next[W];
`else
            data_reg  <= acc_next;
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            valid_reg <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE) && !clr;
  assign out_valid = valid_reg;
  assign out_data  = data_reg;
`ifdef IFNS_RANGE_CHECK_EN
  assign out_err   = err_reg;
`else
  assign out_err   = 1'b0;
`endif

endmodule

// File: tb/tb_ifns_decoder_seq.sv
// Directed bench for ifns_decoder_seq: a W=22 and a W=16 instance, hand-computed Fibonacci sums,
// plus backpressure, clr and asynchronous reset scenarios.
module tb_ifns_decoder_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, clr, out_ready;
  logic iv_a, ir_a, ov_a, oe_a;
  logic [30:0] code_a;
  logic [21:0] od_a;
  logic iv_b, ir_b, ov_b, oe_b;
  logic [30:0] code_b;
  logic [15:0] od_b;

  int n_checks = 0;
  int n_pass   = 0;
  bit sel_b    = 1'b0;

  logic        obs_ready, obs_valid, obs_err;
  logic [31:0] obs_data;
  assign obs_ready = sel_b ? ir_b : ir_a;
  assign obs_valid = sel_b ? ov_b : ov_a;
  assign obs_err   = sel_b ? oe_b : oe_a;
  assign obs_data  = sel_b ? {16'd0, od_b} : {10'd0, od_a};

  ifns_decoder_seq #(.N(31), .W(22), .BPC(4)) dut_a (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(iv_a), .in_ready(ir_a), .in_code(code_a),
    .out_valid(ov_a), .out_ready(out_ready), .out_data(od_a), .out_err(oe_a)
  );

  ifns_decoder_seq #(.N(31), .W(16), .BPC(4)) dut_b (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(iv_b), .in_ready(ir_b), .in_code(code_b),
    .out_valid(ov_b), .out_ready(out_ready), .out_data(od_b), .out_err(oe_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [30:0] code);
    if (sel_b) begin code_b = code; iv_b = 1'b1; end
    else       begin code_a = code; iv_a = 1'b1; end
    tick();
    iv_a = 1'b0;
    iv_b = 1'b0;
  endtask

  // Full transaction: accept, wait for result with a cycle bound, check, then hand it off.
  task automatic decode(input string tag, input logic [30:0] code,
                        input logic [31:0] exp_data, input logic exp_err);
    int lat;
    check({tag, "_ready"}, 32'(obs_ready), 32'd1);
    accept(code);
    check({tag, "_busy"}, 32'(obs_ready), 32'd0);
    lat = 0;
    while (!obs_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd8);
    check({tag, "_data"}, obs_data, exp_data);
    check({tag, "_err"}, 32'(obs_err), 32'(exp_err));
    $display("txn %s code=0x%08h data=%0d err=%0d latency=%0d", tag, code, obs_data, obs_err, lat);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_released"}, 32'(obs_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] held;
    bit seen;
    rst = 1'b1; clr = 1'b0; out_ready = 1'b0;
    iv_a = 1'b0; iv_b = 1'b0; code_a = '0; code_b = '0;
    #12;
    check("rst_valid", 32'(ov_a), 32'd0);
    check("rst_data", 32'(od_a), 32'd0);
    check("rst_err", 32'(oe_a), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("idle_ready", 32'(ir_a), 32'd1);

    // Single LSB, then hold the result under backpressure for 5 cycles.
    check("bp_ready", 32'(ir_a), 32'd1);
    accept(31'h00000001);
    begin
      int lat = 0;
      while (!ov_a && lat < 20) begin tick(); lat++; end
      check("bp_latency", 32'(lat), 32'd8);
    end
    check("bp_data", 32'(od_a), 32'd1);
    check("bp_err", 32'(oe_a), 32'd0);
    $display("txn bp code=0x00000001 data=%0d err=%0d", od_a, oe_a);
    held = 32'(od_a);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_hold_valid", 32'(ov_a), 32'd1);
      check("bp_hold_data", 32'(od_a), held);
      check("bp_hold_ready", 32'(ir_a), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_release_valid", 32'(ov_a), 32'd0);
    check("bp_release_ready", 32'(ir_a), 32'd1);

    decode("all30", 31'h3FFFFFFF, 32'd2178308, 1'b0);
    decode("zero", 31'h00000000, 32'd0, 1'b0);
    decode("msb", 31'h40000000, 32'd1346269, 1'b0);
    decode("all31", 31'h7FFFFFFF, 32'd3524577, 1'b0);

    sel_b = 1'b1;
`ifdef IFNS_RANGE_CHECK_EN
    decode("w16_range", 31'h00C00000, 32'd65535, 1'b1);
`else
    decode("w16_range", 31'h00C00000, 32'd9489, 1'b0);
`endif
    decode("w16_small", 31'h00000005, 32'd3, 1'b0);
    sel_b = 1'b0;

    // clr during the third RUN cycle.
    check("clr_ready", 32'(ir_a), 32'd1);
    accept(31'h3FFFFFFF);
    tick();
    tick();
    clr = 1'b1;
    #1;
    check("clr_ready_low", 32'(ir_a), 32'd0);
    tick();
    clr = 1'b0;
    #1;
    check("clr_idle_ready", 32'(ir_a), 32'd1);
    check("clr_valid", 32'(ov_a), 32'd0);
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (ov_a) seen = 1'b1;
    end
    check("clr_no_result", 32'(seen), 32'd0);
    decode("after_clr", 31'h00000003, 32'd2, 1'b0);

    // Asynchronous reset mid-RUN.
    accept(31'h3FFFFFFF);
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(ov_a), 32'd0);
    check("arst_data", 32'(od_a), 32'd0);
    check("arst_err", 32'(oe_a), 32'd0);
    tick();
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (ov_a) seen = 1'b1;
    end
    check("arst_no_result", 32'(seen), 32'd0);
    decode("after_rst", 31'h00000004, 32'd2, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
